// File: rtl/blake2_pkg.sv
// Shared encodings and constants for the BLAKE2 byte-stream front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blake2_pkg;

    localparam int BB_2S = 64;
    localparam int BB_2B = 128;
    localparam int TW_2S = 64;
    localparam int TW_2B = 128;

    typedef enum logic [1:0] {
        CMD_CONF  = 2'd0,
        CMD_START = 2'd1,
        CMD_DATA  = 2'd2,
        CMD_LAST  = 2'd3
    } cmd_t;

    // IDLE: no open message, FILL: message open, FULL: block held for consumer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/blake2_block_assembler_if.sv
// Input beat stream plus block output bundle of the BLAKE2 block assembler.
// Latency: n/a (wiring only).
// Backpressure: valid_i/ready_o on the input side, block_v_o/block_ready_i on the block side.
// Ports: slave = assembler side, master = host/engine side.
interface blake2_block_assembler_if
#(
    parameter int BB = 64,
    parameter int IW = 1,
    parameter int TW = 64
);
    import blake2_pkg::*;

    logic                      valid_i;
    logic                      ready_o;
    cmd_t                      cmd_i;
    logic [8*IW-1:0]           data_i;
    logic [$clog2(IW+1)-1:0]   bytes_i;
    logic [7:0]                kk_o;
    logic [7:0]                nn_o;
    logic                      err_o;
    logic                      block_v_o;
    logic                      block_ready_i;
    logic [8*BB-1:0]           block_o;
    logic                      block_first_o;
    logic                      block_last_o;
    logic [TW-1:0]             block_t_o;

    modport slave (
        input  valid_i, cmd_i, data_i, bytes_i, block_ready_i,
        output ready_o, kk_o, nn_o, err_o, block_v_o, block_o,
               block_first_o, block_last_o, block_t_o
    );

    modport master (
        output valid_i, cmd_i, data_i, bytes_i, block_ready_i,
        input  ready_o, kk_o, nn_o, err_o, block_v_o, block_o,
               block_first_o, block_last_o, block_t_o
    );

endinterface

// File: rtl/blake2_cfg_capture.sv
// Captures kk then nn from consecutive CONF beats; extra CONF beats overwrite nn.
// Latency: kk/nn visible one cycle after the write.
// Backpressure: none; writes are qualified by the parent.
// Ports: clk, nreset, i_we (CONF write), i_clr (index reset), i_dat, o_kk, o_nn.
module blake2_cfg_capture (
    input  logic       clk,
    input  logic       nreset,
    input  logic       i_we,
    input  logic       i_clr,
    input  logic [7:0] i_dat,
    output logic [7:0] o_kk,
    output logic [7:0] o_nn
);
    logic       r_idx;
    logic [7:0] r_kk;
    logic [7:0] r_nn;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_idx <= 1'b0;
            r_kk  <= 8'h00;
            r_nn  <= 8'h00;
        end else if (i_we) begin
            if (!r_idx) begin
                r_kk  <= i_dat;
                r_idx <= 1'b1;
            end else begin
                r_nn  <= i_dat;
            end
        end else if (i_clr) begin
            r_idx <= 1'b0;
        end
    end

    assign o_kk = r_kk;
    assign o_nn = r_nn;

endmodule

// File: rtl/blake2_block_assembler.sv
// Packs a command-tagged byte stream into zero-padded BB-byte BLAKE2 blocks with first/last/t.
// Latency: block_v_o rises one cycle after the completing beat is accepted.
// Backpressure: ready_o low while a block is held (FULL); no bypass, min block period BB/IW+1.
// Ports: clk, nreset, bus (slave modport: input beats in, configuration/error/block out).
module blake2_block_assembler
    import blake2_pkg::*;
#(
    parameter int BB = BB_2S,
    parameter int IW = 1,
    parameter int TW = TW_2S
) (
    input logic                      clk,
    input logic                      nreset,
    blake2_block_assembler_if.slave  bus
);
    localparam int            FW   = $clog2(BB);
    localparam int            CW   = $clog2(IW + 1);
    localparam logic [FW:0]   BB_F = (FW + 1)'(BB);

    state_t          r_state, w_state_nxt;
    logic [8*BB-1:0] r_buf, w_buf_nxt;
    logic [FW-1:0]   r_fill, w_base;
    logic [FW:0]     w_fill_data;
    logic [TW-1:0]   r_t, w_t_nxt, r_blk_t;
    logic            r_first_pend, r_blk_first, r_blk_last, r_err;
    logic            w_acc, w_start, w_pack, w_emit, w_last, w_err_set, w_close, w_cfg_we;
    logic [CW-1:0]   w_nbytes;
    logic [7:0]      w_kk, w_nn;

    assign w_acc       = bus.valid_i && (r_state != ST_FULL);
    assign w_fill_data = {1'b0, r_fill} + (FW + 1)'(IW);

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state plus beat decode
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_pack      = 1'b0;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        w_err_set   = 1'b0;
        w_close     = 1'b0;
        w_cfg_we    = 1'b0;
        w_nbytes    = (bus.cmd_i == CMD_LAST) ? bus.bytes_i : CW'(IW);
        unique case (r_state)
            ST_IDLE: if (bus.valid_i) begin
                case (bus.cmd_i)
                    CMD_CONF:  w_cfg_we = 1'b1;
                    CMD_START: begin
                        w_start = 1'b1; w_pack = 1'b1; w_state_nxt = ST_FILL;
                    end
                    CMD_DATA:  w_err_set = 1'b1;
                    default: begin
                        // Single-beat message: opens and closes in one beat
                        w_start = 1'b1; w_pack = 1'b1; w_emit = 1'b1; w_last = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                endcase
            end
            ST_FILL: if (bus.valid_i) begin
                case (bus.cmd_i)
                    CMD_CONF:  w_err_set = 1'b1;
                    CMD_START: begin
                        w_err_set = 1'b1; w_start = 1'b1; w_pack = 1'b1;
                    end
                    CMD_DATA: begin
                        w_pack = 1'b1;
                        if (w_fill_data == BB_F) begin
                            w_emit = 1'b1; w_state_nxt = ST_FULL;
                        end
                    end
                    default: begin
                        // An empty LAST on a block boundary has nothing to emit
                        if (bus.bytes_i == '0 && r_fill == '0) begin
                            w_err_set = 1'b1; w_close = 1'b1; w_state_nxt = ST_IDLE;
                        end else begin
                            w_pack = 1'b1; w_emit = 1'b1; w_last = 1'b1;
                            w_state_nxt = ST_FULL;
                        end
                    end
                endcase
            end
            ST_FULL: if (bus.block_ready_i) w_state_nxt = r_blk_last ? ST_IDLE : ST_FILL;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Byte packing: bytes at and above fill are always zero, so only the
    // valid bytes of the beat are written and padding comes for free.
    always_comb begin
        w_base    = w_start ? '0 : r_fill;
        w_buf_nxt = w_start ? '0 : r_buf;
        for (int k = 0; k < IW; k++) begin
            if (k < int'(w_nbytes))
                w_buf_nxt[8*(int'(w_base) + k) +: 8] = bus.data_i[8*k +: 8];
        end
        w_t_nxt = (w_start ? '0 : r_t) + TW'(w_nbytes);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_buf        <= '0;
            r_fill       <= '0;
            r_t          <= '0;
            r_first_pend <= 1'b0;
            r_blk_t      <= '0;
            r_blk_first  <= 1'b0;
            r_blk_last   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_pack) begin
                r_buf  <= w_buf_nxt;
                r_t    <= w_t_nxt;
                r_fill <= w_emit ? '0 : (w_base + FW'(w_nbytes));
                if (w_emit) begin
                    r_blk_t      <= w_t_nxt;
                    r_blk_first  <= w_start | r_first_pend;
                    r_blk_last   <= w_last;
                    r_first_pend <= 1'b0;
                end else if (w_start) begin
                    r_first_pend <= 1'b1;
                end
            end else if (w_close) begin
                r_fill       <= '0;
                r_t          <= '0;
                r_first_pend <= 1'b0;
            end else if (r_state == ST_FULL && bus.block_ready_i) begin
                r_buf <= '0;
            end
            if (w_err_set)
                r_err <= 1'b1;
            else if (w_start && bus.cmd_i == CMD_START)
                r_err <= 1'b0;
        end
    end

    blake2_cfg_capture u_cfg (
        .clk    (clk),
        .nreset (nreset),
        .i_we   (w_cfg_we),
        .i_clr  (w_acc && (bus.cmd_i != CMD_CONF)),
        .i_dat  (bus.data_i[7:0]),
        .o_kk   (w_kk),
        .o_nn   (w_nn)
    );

    // Outputs
    always_comb begin
        bus.ready_o       = (r_state != ST_FULL);
        bus.block_v_o     = (r_state == ST_FULL);
        bus.block_o       = r_buf;
        bus.block_first_o = r_blk_first;
        bus.block_last_o  = r_blk_last;
        bus.block_t_o     = r_blk_t;
        bus.err_o         = r_err;
        bus.kk_o          = w_kk;
        bus.nn_o          = w_nn;
    end

endmodule

// File: tb/tb_blake2_block_assembler.sv
module tb_blake2_block_assembler;
    import blake2_pkg::*;

    typedef struct {
        logic [1023:0] blk;
        bit            first;
        bit            last;
        logic [127:0]  t;
    } exp_t;

    logic clk;
    logic nreset;
    int   total = 0;
    int   bad   = 0;
    int   hold_s = 0;
    int   hold_b = 0;
    exp_t qs[$];
    exp_t qb[$];
    logic [7:0] mbuf[$];

    blake2_block_assembler_if #(.BB(64),  .IW(1), .TW(64))  bs();
    blake2_block_assembler_if #(.BB(128), .IW(8), .TW(128)) bb();

    blake2_block_assembler #(.BB(64), .IW(1), .TW(64)) u_s (
        .clk(clk), .nreset(nreset), .bus(bs));
    blake2_block_assembler #(.BB(128), .IW(8), .TW(128)) u_b (
        .clk(clk), .nreset(nreset), .bus(bb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    // Reference model: expected blocks for the message held in mbuf,
    // ending with a LAST beat carrying r bytes (close: empty LAST on a boundary).
    function automatic void push_exp(input bit sel, input int r, input bit close);
        int   bsz, n, nfull, hi;
        exp_t e;
        bsz   = sel ? 128 : 64;
        n     = mbuf.size();
        nfull = (n - r) / bsz;
        for (int b = 0; b <= nfull; b++) begin
            if (b == nfull && close) break;
            hi      = (b == nfull) ? n : (b + 1) * bsz;
            e.blk   = '0;
            e.first = (b == 0);
            e.last  = (b == nfull);
            e.t     = 128'(hi);
            for (int j = b * bsz; j < hi; j++) e.blk[8*(j - b*bsz) +: 8] = mbuf[j];
            if (sel) qb.push_back(e);
            else     qs.push_back(e);
        end
    endfunction

    task automatic beat_s(input cmd_t c, input logic [7:0] d, input logic nb);
        bit acc;
        int guard;
        bs.valid_i = 1'b1; bs.cmd_i = c; bs.data_i = d; bs.bytes_i = nb;
        acc = 1'b0; guard = 0;
        while (!acc) begin
            acc = bs.ready_o;
            @(negedge clk);
            guard++;
            if (!acc && guard > 500) begin
                total++; bad++;
                $display("FAIL s_accept: ready_o=%b for %0d cycles, required 1", bs.ready_o, guard);
                acc = 1'b1;
            end
        end
        bs.valid_i = 1'b0;
    endtask

    task automatic beat_b(input cmd_t c, input logic [63:0] d, input logic [3:0] nb);
        bit acc;
        int guard;
        bb.valid_i = 1'b1; bb.cmd_i = c; bb.data_i = d; bb.bytes_i = nb;
        acc = 1'b0; guard = 0;
        while (!acc) begin
            acc = bb.ready_o;
            @(negedge clk);
            guard++;
            if (!acc && guard > 500) begin
                total++; bad++;
                $display("FAIL b_accept: ready_o=%b for %0d cycles, required 1", bb.ready_o, guard);
                acc = 1'b1;
            end
        end
        bb.valid_i = 1'b0;
    endtask

    task automatic send_msg_s();
        int n;
        n = mbuf.size();
        push_exp(1'b0, 1, 1'b0);
        beat_s(CMD_START, mbuf[0], 1'b0);
        for (int i = 1; i < n - 1; i++) beat_s(CMD_DATA, mbuf[i], 1'b0);
        beat_s(CMD_LAST, mbuf[n-1], 1'b1);
    endtask

    task automatic send_msg_b(input int r, input bit close);
        int          nfb;
        logic [63:0] d;
        cmd_t        c;
        nfb = (mbuf.size() - r) / 8;
        push_exp(1'b1, r, close);
        for (int i = 0; i < nfb; i++) begin
            for (int k = 0; k < 8; k++) d[8*k +: 8] = mbuf[8*i + k];
            c = (i == 0) ? CMD_START : CMD_DATA;
            beat_b(c, d, 4'd0);
        end
        d = {8{8'hAA}};
        for (int k = 0; k < r; k++) d[8*k +: 8] = mbuf[8*nfb + k];
        beat_b(CMD_LAST, d, 4'(r));
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while ((qs.size() != 0 || qb.size() != 0 || bs.block_v_o || bb.block_v_o) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (g >= 3000) begin
            bad++;
            $display("FAIL %s_drain: %0d blocks outstanding, required 0", name, qs.size() + qb.size());
        end
    endtask

    // Scoreboard consumer for the 2s instance
    initial begin : mon_s
        exp_t e;
        int   cnt, fd;
        cnt = 0;
        bs.block_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bs.block_v_o === 1'b1) begin
                total++;
                if (bs.ready_o !== 1'b0) begin
                    bad++; $display("FAIL s_ready_in_full: ready_o=%b required 0", bs.ready_o);
                end
                if (cnt >= hold_s && bs.block_ready_i === 1'b0) begin
                    total++;
                    if (qs.size() == 0) begin
                        bad++; $display("FAIL s_unexpected_block: t=%0d required no block", bs.block_t_o);
                    end else begin
                        e = qs.pop_front();
                        if (bs.block_o !== e.blk[511:0]) begin
                            bad++; fd = 0;
                            for (int j = 63; j >= 0; j--) if (bs.block_o[8*j +: 8] !== e.blk[8*j +: 8]) fd = j;
                            $display("FAIL s_block byte %0d: got %h required %h", fd, bs.block_o[8*fd +: 8], e.blk[8*fd +: 8]);
                        end
                        total++;
                        if (bs.block_first_o !== e.first) begin
                            bad++; $display("FAIL s_first: got %b required %b", bs.block_first_o, e.first);
                        end
                        total++;
                        if (bs.block_last_o !== e.last) begin
                            bad++; $display("FAIL s_last: got %b required %b", bs.block_last_o, e.last);
                        end
                        total++;
                        if (bs.block_t_o !== e.t[63:0]) begin
                            bad++; $display("FAIL s_t: got %0d required %0d", bs.block_t_o, e.t[63:0]);
                        end
                    end
                    bs.block_ready_i = 1'b1;
                end
                cnt++;
            end else begin
                bs.block_ready_i = 1'b0;
                cnt = 0;
            end
        end
    end

    // Scoreboard consumer for the 2b instance
    initial begin : mon_b
        exp_t e;
        int   cnt, fd;
        cnt = 0;
        bb.block_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bb.block_v_o === 1'b1) begin
                total++;
                if (bb.ready_o !== 1'b0) begin
                    bad++; $display("FAIL b_ready_in_full: ready_o=%b required 0", bb.ready_o);
                end
                if (cnt >= hold_b && bb.block_ready_i === 1'b0) begin
                    total++;
                    if (qb.size() == 0) begin
                        bad++; $display("FAIL b_unexpected_block: t=%0d required no block", bb.block_t_o);
                    end else begin
                        e = qb.pop_front();
                        if (bb.block_o !== e.blk) begin
                            bad++; fd = 0;
                            for (int j = 127; j >= 0; j--) if (bb.block_o[8*j +: 8] !== e.blk[8*j +: 8]) fd = j;
                            $display("FAIL b_block byte %0d: got %h required %h", fd, bb.block_o[8*fd +: 8], e.blk[8*fd +: 8]);
                        end
                        total++;
                        if (bb.block_first_o !== e.first) begin
                            bad++; $display("FAIL b_first: got %b required %b", bb.block_first_o, e.first);
                        end
                        total++;
                        if (bb.block_last_o !== e.last) begin
                            bad++; $display("FAIL b_last: got %b required %b", bb.block_last_o, e.last);
                        end
                        total++;
                        if (bb.block_t_o !== e.t) begin
                            bad++; $display("FAIL b_t: got %0d required %0d", bb.block_t_o, e.t);
                        end
                    end
                    bb.block_ready_i = 1'b1;
                end
                cnt++;
            end else begin
                bb.block_ready_i = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic test_reset();
        nreset = 1'b0;
        bs.valid_i = 1'b0; bs.cmd_i = CMD_CONF; bs.data_i = '0; bs.bytes_i = '0;
        bb.valid_i = 1'b0; bb.cmd_i = CMD_CONF; bb.data_i = '0; bb.bytes_i = '0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        total++; if (bs.ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b required 1", bs.ready_o); end
        total++; if (bs.block_v_o !== 1'b0) begin bad++; $display("FAIL rst_block_v: got %b required 0", bs.block_v_o); end
        total++; if (bs.err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b required 0", bs.err_o); end
        total++; if (bs.kk_o !== 8'h00 || bs.nn_o !== 8'h00) begin bad++; $display("FAIL rst_kknn: got %h/%h required 00/00", bs.kk_o, bs.nn_o); end
        total++; if (bs.block_o !== '0 || bs.block_t_o !== '0) begin bad++; $display("FAIL rst_block: t=%0d nonzero block, required zero", bs.block_t_o); end
        total++; if (bs.block_first_o !== 1'b0 || bs.block_last_o !== 1'b0) begin bad++; $display("FAIL rst_flags: got %b%b required 00", bs.block_first_o, bs.block_last_o); end
        total++; if (bb.ready_o !== 1'b1 || bb.block_v_o !== 1'b0) begin bad++; $display("FAIL rst_b_hs: ready=%b v=%b required 1/0", bb.ready_o, bb.block_v_o); end
    endtask

    task automatic test_config();
        bit seen;
        beat_s(CMD_CONF, 8'h20, 1'b0);
        beat_s(CMD_CONF, 8'h40, 1'b0);
        total++; if (bs.kk_o !== 8'h20) begin bad++; $display("FAIL cfg_kk: got %h required 20", bs.kk_o); end
        total++; if (bs.nn_o !== 8'h40) begin bad++; $display("FAIL cfg_nn: got %h required 40", bs.nn_o); end
        beat_s(CMD_CONF, 8'h30, 1'b0);
        total++; if (bs.nn_o !== 8'h30 || bs.kk_o !== 8'h20) begin bad++; $display("FAIL cfg_overwrite: got kk=%h nn=%h required 20/30", bs.kk_o, bs.nn_o); end
        beat_s(CMD_DATA, 8'h55, 1'b0);
        seen = 1'b0;
        repeat (4) begin
            if (bs.block_v_o !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        total++; if (bs.err_o !== 1'b1) begin bad++; $display("FAIL cfg_data_idle_err: got %b required 1", bs.err_o); end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL cfg_data_idle_block: got block, required none"); end
    endtask

    task automatic test_abc();
        mbuf = '{8'h61, 8'h62, 8'h63};
        send_msg_s();
        wait_drain("abc");
        total++; if (bs.err_o !== 1'b0) begin bad++; $display("FAIL abc_err_clear: got %b required 0", bs.err_o); end
    endtask

    task automatic test_full_block();
        mbuf.delete();
        for (int i = 0; i < 64; i++) mbuf.push_back(8'(i));
        send_msg_s();
        wait_drain("full64");
    endtask

    task automatic test_restart();
        beat_s(CMD_START, 8'h11, 1'b0);
        mbuf = '{8'h61, 8'h62, 8'h63};
        send_msg_s();
        wait_drain("restart");
        total++; if (bs.err_o !== 1'b1) begin bad++; $display("FAIL restart_err: got %b required 1", bs.err_o); end
    endtask

    task automatic test_mid_reset();
        int g;
        hold_s = 1000000;
        mbuf = '{8'h61, 8'h62, 8'h63};
        send_msg_s();
        g = 0;
        while (bs.block_v_o !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        total++; if (bs.block_v_o !== 1'b1) begin bad++; $display("FAIL mrst_block_v_before: got %b required 1", bs.block_v_o); end
        #2 nreset = 1'b0;
        #1;
        total++; if (bs.block_v_o !== 1'b0 || bs.ready_o !== 1'b1) begin bad++; $display("FAIL mrst_hs: v=%b ready=%b required 0/1", bs.block_v_o, bs.ready_o); end
        total++; if (bs.block_o !== '0 || bs.block_t_o !== '0) begin bad++; $display("FAIL mrst_block: t=%0d, required zero block and t=0", bs.block_t_o); end
        total++; if (bs.kk_o !== 8'h00 || bs.err_o !== 1'b0 || bs.block_first_o !== 1'b0 || bs.block_last_o !== 1'b0) begin
            bad++; $display("FAIL mrst_regs: kk=%h err=%b first=%b last=%b required 00/0/0/0", bs.kk_o, bs.err_o, bs.block_first_o, bs.block_last_o);
        end
        qs.delete();
        @(negedge clk);
        nreset = 1'b1;
        hold_s = 0;
        @(negedge clk);
        send_msg_s();
        wait_drain("mid_reset");
    endtask

    task automatic test_empty();
        mbuf.delete();
        push_exp(1'b0, 0, 1'b0);
        beat_s(CMD_LAST, 8'h5A, 1'b0);
        wait_drain("empty");
        total++; if (bs.err_o !== 1'b0) begin bad++; $display("FAIL empty_err: got %b required 0", bs.err_o); end
    endtask

    task automatic test_backpressure();
        hold_b = 10;
        mbuf.delete();
        for (int i = 0; i < 130; i++) mbuf.push_back(8'(i * 7 + 3));
        send_msg_b(2, 1'b0);
        wait_drain("backpressure");
        hold_b = 0;
    endtask

    task automatic test_close_err();
        mbuf.delete();
        for (int i = 0; i < 128; i++) mbuf.push_back(8'(255 - i));
        send_msg_b(0, 1'b1);
        wait_drain("close_err");
        total++; if (bb.err_o !== 1'b1) begin bad++; $display("FAIL close_err_flag: got %b required 1", bb.err_o); end
        total++; if (bb.ready_o !== 1'b1 || bb.block_v_o !== 1'b0) begin bad++; $display("FAIL close_err_idle: ready=%b v=%b required 1/0", bb.ready_o, bb.block_v_o); end
    endtask

    task automatic test_back_to_back();
        mbuf.delete();
        for (int i = 0; i < 24; i++) mbuf.push_back(8'(i + 8'h40));
        send_msg_b(8, 1'b0);
        mbuf.delete();
        for (int i = 0; i < 9; i++) mbuf.push_back(8'(i * 3 + 1));
        send_msg_b(1, 1'b0);
        wait_drain("back_to_back");
        total++; if (bb.err_o !== 1'b0) begin bad++; $display("FAIL b2b_err: got %b required 0", bb.err_o); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_abc();
        test_full_block();
        test_restart();
        test_mid_reset();
        test_empty();
        test_backpressure();
        test_close_err();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
